// File: rtl/clint_timer.sv
// Core-local interruptor: prescaled 64-bit mtime, mtimecmp and msip
// on a single-outstanding register bus, feeding MTIP/MSIP.
module clint_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        timer_int,
    output logic        sw_int
);

    localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] pcnt;
    logic        msip;

    logic        accept;
    logic        wr;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        hit;
    logic [31:0] rdata_mux;

    assign req_ready = !resp_valid;
    assign accept    = req_valid && req_ready;
    assign wr        = accept && req_we;

    // misaligned offsets never equal a mapped word address
    assign sel_msip    = req_addr == 16'h0000;
    assign sel_cmp_lo  = req_addr == 16'h4000;
    assign sel_cmp_hi  = req_addr == 16'h4004;
    assign sel_time_lo = req_addr == 16'hBFF8;
    assign sel_time_hi = req_addr == 16'hBFFC;
    assign hit = sel_msip | sel_cmp_lo | sel_cmp_hi
               | sel_time_lo | sel_time_hi;

    always_comb begin
        rdata_mux = '0;
        unique case (1'b1)
            sel_msip:    rdata_mux = {31'd0, msip};
            sel_cmp_lo:  rdata_mux = mtimecmp[31:0];
            sel_cmp_hi:  rdata_mux = mtimecmp[63:32];
            sel_time_lo: rdata_mux = mtime[31:0];
            sel_time_hi: rdata_mux = mtime[63:32];
            default:     rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= accept;
            resp_err   <= accept && !hit;
            resp_rdata <= (accept && !req_we) ? rdata_mux : 32'd0;
        end
    end

    // a bus write to either half overrides the prescaler tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
            pcnt  <= '0;
        end else if (wr && sel_time_lo) begin
            mtime[31:0] <= req_wdata;
            pcnt        <= '0;
        end else if (wr && sel_time_hi) begin
            mtime[63:32] <= req_wdata;
            pcnt         <= '0;
        end else if (pcnt == PMAX) begin
            mtime <= mtime + 64'd1;
            pcnt  <= '0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr && sel_cmp_lo) mtimecmp[31:0]  <= req_wdata;
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= req_wdata;
            if (wr && sel_msip)   msip            <= req_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_int <= 1'b0;
            sw_int    <= 1'b0;
        end else begin
            timer_int <= mtime >= mtimecmp;
            sw_int    <= msip;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (PRESCALE 1 and 4) on a shared bus,
// checked every cycle against a time-based model plus literal pins.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy [2];
    logic        rv_o [2];
    logic [31:0] rd_o [2];
    logic        err_o [2];
    logic        ti_o [2];
    logic        si_o [2];

    always #5 clk = ~clk;

    clint_timer #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_o[0]), .resp_rdata(rd_o[0]), .resp_err(err_o[0]),
        .timer_int(ti_o[0]), .sw_int(si_o[0])
    );

    clint_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_o[1]), .resp_rdata(rd_o[1]), .resp_err(err_o[1]),
        .timer_int(ti_o[1]), .sw_int(si_o[1])
    );

    int checks = 0;
    int failures = 0;

    // model: mtime(e) = base + (e - bedge) / P, e counts edges since reset
    int          pre [2] = '{1, 4};
    logic [63:0] base [2];
    longint      bedge [2];
    logic [63:0] cmp [2];
    bit          msip_m [2];
    bit          ti_m [2];
    bit          si_m [2];
    bit          rv_m [2];
    bit          err_m [2];
    logic [31:0] rd_m [2];
    longint      k;
    bit          last_acc;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] mt(int i, longint e);
        return base[i] + 64'((e - bedge[i]) / pre[i]);
    endfunction

    function automatic void model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            base[i] = '0;
            bedge[i] = 0;
            cmp[i] = '1;
            msip_m[i] = 0;
            ti_m[i] = 0;
            si_m[i] = 0;
            rv_m[i] = 0;
            err_m[i] = 0;
            rd_m[i] = '0;
        end
    endfunction

    function automatic void model_step();
        logic [63:0] now;
        bit acc;
        bit nti;
        bit nsi;
        k++;
        last_acc = 0;
        for (int i = 0; i < 2; i++) begin
            now = mt(i, k - 1);
            nti = now >= cmp[i];
            nsi = msip_m[i];
            acc = req_valid && !rv_m[i];
            if (i == 0) last_acc = acc;
            rv_m[i] = acc;
            err_m[i] = 0;
            rd_m[i] = '0;
            if (acc) begin
                case (req_addr)
                    16'h0000: begin
                        if (req_we) msip_m[i] = req_wdata[0];
                        else rd_m[i] = {31'd0, msip_m[i]};
                    end
                    16'h4000: begin
                        if (req_we) cmp[i][31:0] = req_wdata;
                        else rd_m[i] = cmp[i][31:0];
                    end
                    16'h4004: begin
                        if (req_we) cmp[i][63:32] = req_wdata;
                        else rd_m[i] = cmp[i][63:32];
                    end
                    16'hBFF8: begin
                        if (req_we) begin
                            base[i] = {now[63:32], req_wdata};
                            bedge[i] = k;
                        end else rd_m[i] = now[31:0];
                    end
                    16'hBFFC: begin
                        if (req_we) begin
                            base[i] = {req_wdata, now[31:0]};
                            bedge[i] = k;
                        end else rd_m[i] = now[63:32];
                    end
                    default: err_m[i] = 1;
                endcase
            end
            ti_m[i] = nti;
            si_m[i] = nsi;
        end
    endfunction

    function automatic void compare();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("req_ready[%0d]", i), 64'(rdy[i]), 64'(!rv_m[i]));
            check($sformatf("resp_valid[%0d]", i), 64'(rv_o[i]), 64'(rv_m[i]));
            check($sformatf("timer_int[%0d]", i), 64'(ti_o[i]), 64'(ti_m[i]));
            check($sformatf("sw_int[%0d]", i), 64'(si_o[i]), 64'(si_m[i]));
            if (rv_m[i]) begin
                check($sformatf("resp_rdata[%0d]", i), 64'(rd_o[i]),
                      64'(rd_m[i]));
                check($sformatf("resp_err[%0d]", i), 64'(err_o[i]),
                      64'(err_m[i]));
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic bus(input bit we, input logic [15:0] addr,
                       input logic [31:0] data,
                       output logic [31:0] d1, output logic [31:0] d4);
        bit done = 0;
        req_valid = 1;
        req_we = we;
        req_addr = addr;
        req_wdata = data;
        for (int t = 0; t < 4 && !done; t++) begin
            cyc();
            done = last_acc;
        end
        if (!done) begin
            failures++;
            $display("FAIL bus_timeout addr=%0h", addr);
        end
        d1 = rd_o[0];
        d4 = rd_o[1];
        req_valid = 0;
    endtask

    logic [31:0] a;
    logic [31:0] b;
    int pulses;
    logic [15:0] amap [8] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                              16'hBFFC, 16'h0008, 16'h4001, 16'hBFFA};

    initial begin
        reset = 1;
        req_valid = 0;
        req_we = 0;
        req_addr = '0;
        req_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 64'(rdy[i]), 64'd1);
            check("rst_resp_valid", 64'(rv_o[i]), 64'd0);
            check("rst_rdata", 64'(rd_o[i]), 64'd0);
            check("rst_err", 64'(err_o[i]), 64'd0);
            check("rst_timer", 64'(ti_o[i]), 64'd0);
            check("rst_sw", 64'(si_o[i]), 64'd0);
        end
        reset = 0;
        model_reset();

        // idle then read mtime lo
        repeat (10) cyc();
        bus(0, 16'hBFF8, 0, a, b);
        check("idle_mtime_p1", 64'(a), 64'd10);
        check("idle_mtime_p4", 64'(b), 64'd2);

        // software interrupt
        bus(1, 16'h0000, 32'hFFFF_FFFF, a, b);
        check("sw_before", 64'(si_o[0]), 64'd0);
        cyc();
        check("sw_set", 64'(si_o[0]), 64'd1);
        bus(0, 16'h0000, 0, a, b);
        check("msip_read", 64'(a), 64'd1);
        bus(1, 16'h0000, 0, a, b);
        cyc();
        check("sw_clear", 64'(si_o[0]), 64'd0);

        // timer compare at 50
        bus(1, 16'h4004, 0, a, b);
        bus(1, 16'h4000, 50, a, b);
        bus(1, 16'hBFF8, 40, a, b);
        repeat (10) cyc();
        check("cmp50_below", 64'(ti_o[0]), 64'd0);
        cyc();
        check("cmp50_rise", 64'(ti_o[0]), 64'd1);
        repeat (5) cyc();
        check("cmp50_hold", 64'(ti_o[0]), 64'd1);
        bus(1, 16'h4000, 32'hFFFF_FFFF, a, b);
        bus(1, 16'h4004, 32'hFFFF_FFFF, a, b);
        cyc();
        check("cmp_max_fall", 64'(ti_o[0]), 64'd0);

        // wrap with mtimecmp = 1_0000_0000
        bus(1, 16'h4000, 0, a, b);
        bus(1, 16'h4004, 1, a, b);
        bus(1, 16'hBFFC, 32'hFFFF_FFFF, a, b);
        bus(1, 16'hBFF8, 32'hFFFF_FFFE, a, b);
        cyc();
        cyc();
        check("wrap_before", 64'(ti_o[0]), 64'd1);
        cyc();
        check("wrap_after", 64'(ti_o[0]), 64'd0);
        bus(0, 16'hBFFC, 0, a, b);
        check("wrap_hi", 64'(a), 64'd0);

        // prescaler hold after mtime write
        cyc();
        bus(1, 16'hBFF8, 100, a, b);
        bus(0, 16'hBFF8, 0, a, b);
        check("ps4_r0", 64'(b), 64'd100);
        check("ps1_r0", 64'(a), 64'd101);
        bus(0, 16'hBFF8, 0, a, b);
        check("ps4_r1", 64'(b), 64'd100);
        check("ps1_r1", 64'(a), 64'd103);
        bus(0, 16'hBFF8, 0, a, b);
        check("ps4_r2", 64'(b), 64'd101);

        // unmapped and misaligned
        bus(1, 16'h0008, 32'hFFFF_FFFF, a, b);
        check("err_0008", 64'(err_o[0]), 64'd1);
        bus(0, 16'h4001, 0, a, b);
        check("err_4001", 64'(err_o[0]), 64'd1);
        check("err_rdata", 64'(a), 64'd0);
        bus(0, 16'h0000, 0, a, b);
        check("err_no_msip", 64'(a), 64'd0);

        // continuous valid
        cyc();
        pulses = 0;
        req_valid = 1;
        req_we = 0;
        req_addr = 16'h4004;
        for (int t = 0; t < 8; t++) begin
            cyc();
            pulses += int'(rv_o[0]);
        end
        req_valid = 0;
        check("held_pulses", 64'(pulses), 64'd4);

        // random traffic
        for (int t = 0; t < 600; t++) begin
            req_valid = 1'($urandom % 2);
            req_we = 1'($urandom % 2);
            req_addr = amap[$urandom % 8];
            req_wdata = ($urandom % 2) ? $urandom : ($urandom % 64);
            cyc();
        end

        // reset with a response pending
        req_valid = 0;
        cyc();
        req_valid = 1;
        req_we = 0;
        req_addr = 16'hBFF8;
        cyc();
        check("mid_pending", 64'(rv_o[0]), 64'd1);
        reset = 1;
        #1;
        check("mid_drop", 64'(rv_o[0]) | 64'(rv_o[1]), 64'd0);
        check("mid_ready", 64'(rdy[0]), 64'd1);
        check("mid_timer", 64'(ti_o[0]), 64'd0);
        req_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        repeat (3) cyc();
        bus(0, 16'hBFF8, 0, a, b);
        check("post_rst_p1", 64'(a), 64'd3);
        check("post_rst_p4", 64'(b), 64'd0);
        bus(0, 16'h4004, 0, a, b);
        check("post_rst_cmp", 64'(a), 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
